scr1_dbgc_hart_ctrl: RTL and testbench
======================================

// Module: scr1_dbgc_hart_ctrl
// PURPOSE
//  DBGC-side master of the hart debug-command interface.
//  - Takes halt/run requests, RUNCTRL, instruction and DDR writes from the DBGC register block (host side).
//  - Drives them to the hart debug agent with a req/ack/nack handshake.
//  - Returns completion status, sampled hart state and hart-written DDR data to the host.
// PARAMETERS
//  CMD_TOUT  256  cycles with hart_cmd_req high before local abort; must exceed the hart-side timeout (64)
// PORTS
//  clk                 in   1    core clock (single clock domain)
//  rst_n               in   1    asynchronous active-low reset
//  host_cmd_vd         in   1    1-cycle strobe: start command (ignored while host_busy)
//  host_cmd            in   1    type_scr1_dbgc_hart_dbg_mode_e: DBG_MODE=halt, RUN_MODE=run
//  host_busy           out  1    command in flight
//  host_done           out  1    1-cycle pulse when command completes
//  host_status         out  2    held until next start: 00 ack, 01 nack, 10 local timeout
//  host_runctrl_we     in   1    write RUNCTRL shadow
//  host_runctrl        in   struct  type_scr1_dbgc_hart_runctrl_s write data
//  host_instr_we       in   1    write instruction register
//  host_instr          in   32   instruction data
//  host_dreg_we        in   1    host write to DDR (DBGC->core)
//  host_dreg_wdata     in   32   DDR write data
//  host_dreg_rdata     out  32   last hart-written DDR value
//  host_dreg_upd       out  1    sticky: hart wrote DDR since last host_dreg_we
//  host_hart_state     out  struct  registered copy of dbgc_hart_state
//  dbgc_hart_cmd       out  1    command to hart
//  dbgc_hart_cmd_req   out  1    request
//  dbgc_hart_cmd_ack   in   1    hart accepted
//  dbgc_hart_cmd_nack  in   1    hart rejected
//  dbgc_hart_runctrl   out  struct  RUNCTRL shadow
//  dbgc_hart_state     in   struct  hart state
//  dbgc_hart_instr     out  32   instruction register
//  dbgc_hart_dreg_out  out  32   DDR DBGC->core
//  dbgc_hart_dreg_in   in   32   DDR core->DBGC
//  dbgc_hart_dreg_wr   in   1    hart DDR write strobe
// BEHAVIOUR
//  Reset values
//   - Reset state is IDLE.
//   - host_busy, host_done, host_dreg_upd and dbgc_hart_cmd_req reset to 0; host_status resets to 00.
//   - All data registers (RUNCTRL shadow, instruction, DDR, host_hart_state) reset to 0.
//   - dbgc_hart_cmd resets to RUN_MODE.
//  FSM
//   - IDLE -> REQ on host_cmd_vd: latch host_cmd into dbgc_hart_cmd, load the timeout counter with CMD_TOUT-1.
//   - REQ: dbgc_hart_cmd_req=1 and host_busy=1, both registered, so req rises the cycle after the strobe.
//     - ack -> DONE with status 00.
//     - nack -> DONE with status 01; nack has priority when ack and nack arrive in the same cycle.
//     - Counter reaches 0 -> DONE with status 10.
//   - DONE: req=0, host_done=1 for one cycle, then IDLE. A new command is accepted at the earliest two cycles
//     after the response.
//   - dbgc_hart_cmd is stable for the whole of REQ.
//  Register writes
//   - RUNCTRL, instruction and DDR writes take effect on outputs the next cycle.
//   - RUNCTRL writes are ignored while in REQ, so RUNCTRL is stable while a run command is in flight.
//  DDR
//   - dbgc_hart_dreg_wr captures dbgc_hart_dreg_in into host_dreg_rdata and sets host_dreg_upd.
//   - If host_dreg_we and dbgc_hart_dreg_wr occur in the same cycle:
//     - dbgc_hart_dreg_out takes the host data;
//     - host_dreg_rdata takes the hart data;
//     - host_dreg_upd ends at 1.
//   - dbgc_hart_dreg_out is written only by the host.
//  Hart state: host_hart_state <= dbgc_hart_state every cycle.
//  Reset mid-operation: asynchronous return to IDLE, req drops immediately, no host_done.
// CONFIGURATION
//  SCR1_DBGC_HART_CMD_TOUT_EN
//   - Defined: local timeout counter present; status 10 is possible.
//   - Undefined: no counter; REQ waits indefinitely for ack/nack and status 10 never occurs.
// STRUCTURE
//  - Status encoding enum type_scr1_dbgc_hart_cmd_sts_e and the CMD_TOUT default belong in scr1_dbgc.svh,
//    next to the existing hart runctrl/state types.
//  - One sub-module is natural: scr1_dbgc_tout_cnt (loadable down-counter with zero flag).
// TESTING
//  1 Halt, ack on 3rd REQ cycle -> req high exactly 3 cycles, host_done 1 cycle, status 00, busy low after.
//  2 Run while hart running, nack on 1st REQ cycle -> status 01, req high 1 cycle.
//  3 (TOUT_EN, CMD_TOUT=8) no response -> req high 8 cycles, status 10; without macro req stays high 100+ cycles.
//  4 ack+nack same cycle -> status 01; host_cmd_vd during REQ ignored, dbgc_hart_cmd unchanged.
//  5 host_dreg_we 0xA5A5_0001 and hart dreg_wr 0x1234_5678 same cycle -> dreg_out=0xA5A5_0001,
//    rdata=0x1234_5678, upd=1.
//  6 rst_n low in REQ -> req=0 asynchronously, busy=0, status 00, no done pulse.

Source files
------------

// File: rtl/scr1_dbgc_hart_ctrl_pkg.sv
// Shared types for the DBGC hart debug-command master: command/status encodings,
// RUNCTRL and hart-state records, controller FSM states and the default command timeout.
package scr1_dbgc_hart_ctrl_pkg;

  localparam int unsigned SCR1_DBGC_CMD_TOUT = 256;

  typedef enum logic {
    RUN_MODE = 1'b0,
    DBG_MODE = 1'b1
  } type_scr1_dbgc_hart_dbg_mode_e;

  typedef enum logic [1:0] {
    SCR1_DBGC_HART_STS_ACK  = 2'b00,
    SCR1_DBGC_HART_STS_NACK = 2'b01,
    SCR1_DBGC_HART_STS_TOUT = 2'b10
  } type_scr1_dbgc_hart_cmd_sts_e;

  typedef struct packed {
    logic irq_dsbl;
    logic fetch_src;
    logic pc_advmt_dsbl;
    logic hwbrkpt_dsbl;
    logic redirect_sstep;
    logic redirect_rst_brkpt;
  } type_scr1_dbgc_hart_runctrl_s;

  typedef struct packed {
    logic       rst;
    logic       rst_stky;
    logic       halted;
    logic       timeout;
    logic       err;
    logic [2:0] dmode_cause;
  } type_scr1_dbgc_hart_state_s;

  typedef enum logic [1:0] {
    FSM_IDLE = 2'b00,
    FSM_REQ  = 2'b01,
    FSM_DONE = 2'b10
  } type_scr1_dbgc_hart_ctrl_fsm_e;

endpackage

// File: rtl/scr1_dbgc_tout_cnt.sv
// Loadable down-counter with a zero flag; it stops at zero and waits for the next load.
module scr1_dbgc_tout_cnt #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         zero
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/scr1_dbgc_hart_ctrl.sv
// DBGC-side master of the hart debug-command req/ack/nack handshake, plus RUNCTRL/instruction/DDR shadows.
// Build option SCR1_DBGC_HART_CMD_TOUT_EN adds the local command timeout (CMD_TOUT cycles).
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  FSM_IDLE | no command in flight, accepts host_cmd_vd
//  FSM_REQ  | dbgc_hart_cmd_req high, waiting for ack/nack (or timeout)
//  FSM_DONE | one-cycle host_done pulse, status valid
module scr1_dbgc_hart_ctrl
  import scr1_dbgc_hart_ctrl_pkg::*;
`ifdef SCR1_DBGC_HART_CMD_TOUT_EN
#(
  parameter int unsigned CMD_TOUT = SCR1_DBGC_CMD_TOUT
)
`endif
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          host_cmd_vd,
  input  type_scr1_dbgc_hart_dbg_mode_e host_cmd,
  output logic                          host_busy,
  output logic                          host_done,
  output type_scr1_dbgc_hart_cmd_sts_e  host_status,
  input  logic                          host_runctrl_we,
  input  type_scr1_dbgc_hart_runctrl_s  host_runctrl,
  input  logic                          host_instr_we,
  input  logic [31:0]                   host_instr,
  input  logic                          host_dreg_we,
  input  logic [31:0]                   host_dreg_wdata,
  output logic [31:0]                   host_dreg_rdata,
  output logic                          host_dreg_upd,
  output type_scr1_dbgc_hart_state_s    host_hart_state,
  output type_scr1_dbgc_hart_dbg_mode_e dbgc_hart_cmd,
  output logic                          dbgc_hart_cmd_req,
  input  logic                          dbgc_hart_cmd_ack,
  input  logic                          dbgc_hart_cmd_nack,
  output type_scr1_dbgc_hart_runctrl_s  dbgc_hart_runctrl,
  input  type_scr1_dbgc_hart_state_s    dbgc_hart_state,
  output logic [31:0]                   dbgc_hart_instr,
  output logic [31:0]                   dbgc_hart_dreg_out,
  input  logic [31:0]                   dbgc_hart_dreg_in,
  input  logic                          dbgc_hart_dreg_wr
);

  type_scr1_dbgc_hart_ctrl_fsm_e state;

`ifdef SCR1_DBGC_HART_CMD_TOUT_EN
  localparam int unsigned TOUT_W = (CMD_TOUT > 2) ? $clog2(CMD_TOUT) : 1;

  logic tout_load;
  logic tout_dec;
  logic tout_zero;

  assign tout_load = (state == FSM_IDLE) && host_cmd_vd;
  assign tout_dec  = (state == FSM_REQ);

  scr1_dbgc_tout_cnt #(
    .W (TOUT_W)
  ) i_tout_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tout_load),
    .load_val (TOUT_W'(CMD_TOUT - 1)),
    .dec      (tout_dec),
    .zero     (tout_zero)
  );
`endif

  // busy stays high through DONE so a strobe there is visibly refused rather than silently dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= FSM_IDLE;
      dbgc_hart_cmd_req <= 1'b0;
      host_busy         <= 1'b0;
      host_done         <= 1'b0;
      host_status       <= SCR1_DBGC_HART_STS_ACK;
      dbgc_hart_cmd     <= RUN_MODE;
    end else begin
      case (state)
        FSM_IDLE: begin
          host_done <= 1'b0;
          if (host_cmd_vd) begin
            state             <= FSM_REQ;
            dbgc_hart_cmd     <= host_cmd;
            dbgc_hart_cmd_req <= 1'b1;
            host_busy         <= 1'b1;
          end
        end
        FSM_REQ: begin
          if (dbgc_hart_cmd_nack) begin
            state             <= FSM_DONE;
            dbgc_hart_cmd_req <= 1'b0;
            host_done         <= 1'b1;
            host_status       <= SCR1_DBGC_HART_STS_NACK;
          end else if (dbgc_hart_cmd_ack) begin
            state             <= FSM_DONE;
            dbgc_hart_cmd_req <= 1'b0;
            host_done         <= 1'b1;
            host_status       <= SCR1_DBGC_HART_STS_ACK;
          end
`ifdef SCR1_DBGC_HART_CMD_TOUT_EN
          else if (tout_zero) begin
            state             <= FSM_DONE;
            dbgc_hart_cmd_req <= 1'b0;
            host_done         <= 1'b1;
            host_status       <= SCR1_DBGC_HART_STS_TOUT;
          end
`endif
        end
        FSM_DONE: begin
          state     <= FSM_IDLE;
          host_done <= 1'b0;
          host_busy <= 1'b0;
        end
        default: begin
          state             <= FSM_IDLE;
          dbgc_hart_cmd_req <= 1'b0;
          host_busy         <= 1'b0;
          host_done         <= 1'b0;
        end
      endcase
    end
  end

  // RUNCTRL is frozen while a command is being requested so a run sees a stable configuration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dbgc_hart_runctrl  <= '0;
      dbgc_hart_instr    <= '0;
      dbgc_hart_dreg_out <= '0;
      host_dreg_rdata    <= '0;
      host_dreg_upd      <= 1'b0;
      host_hart_state    <= '0;
    end else begin
      if (host_runctrl_we && (state != FSM_REQ)) begin
        dbgc_hart_runctrl <= host_runctrl;
      end
      if (host_instr_we) begin
        dbgc_hart_instr <= host_instr;
      end
      if (host_dreg_we) begin
        dbgc_hart_dreg_out <= host_dreg_wdata;
      end
      if (dbgc_hart_dreg_wr) begin
        host_dreg_rdata <= dbgc_hart_dreg_in;
      end
      if (dbgc_hart_dreg_wr) begin
        host_dreg_upd <= 1'b1;
      end else if (host_dreg_we) begin
        host_dreg_upd <= 1'b0;
      end
      host_hart_state <= dbgc_hart_state;
    end
  end

endmodule

// File: tb/tb_scr1_dbgc_hart_ctrl.sv
// Self-checking bench for scr1_dbgc_hart_ctrl: register/DDR vector table plus command handshake sequences.
// With SCR1_DBGC_HART_CMD_TOUT_EN defined the DUT is built with CMD_TOUT=8.
module tb_scr1_dbgc_hart_ctrl;
  import scr1_dbgc_hart_ctrl_pkg::*;

  logic                          clk;
  logic                          rst_n;
  logic                          host_cmd_vd;
  type_scr1_dbgc_hart_dbg_mode_e host_cmd;
  logic                          host_busy;
  logic                          host_done;
  type_scr1_dbgc_hart_cmd_sts_e  host_status;
  logic                          host_runctrl_we;
  type_scr1_dbgc_hart_runctrl_s  host_runctrl;
  logic                          host_instr_we;
  logic [31:0]                   host_instr;
  logic                          host_dreg_we;
  logic [31:0]                   host_dreg_wdata;
  logic [31:0]                   host_dreg_rdata;
  logic                          host_dreg_upd;
  type_scr1_dbgc_hart_state_s    host_hart_state;
  type_scr1_dbgc_hart_dbg_mode_e dbgc_hart_cmd;
  logic                          dbgc_hart_cmd_req;
  logic                          dbgc_hart_cmd_ack;
  logic                          dbgc_hart_cmd_nack;
  type_scr1_dbgc_hart_runctrl_s  dbgc_hart_runctrl;
  type_scr1_dbgc_hart_state_s    dbgc_hart_state;
  logic [31:0]                   dbgc_hart_instr;
  logic [31:0]                   dbgc_hart_dreg_out;
  logic [31:0]                   dbgc_hart_dreg_in;
  logic                          dbgc_hart_dreg_wr;

  int n_cmp = 0;
  int n_err = 0;

`ifdef SCR1_DBGC_HART_CMD_TOUT_EN
  scr1_dbgc_hart_ctrl #(.CMD_TOUT(8)) dut (
`else
  scr1_dbgc_hart_ctrl dut (
`endif
    .clk                (clk),
    .rst_n              (rst_n),
    .host_cmd_vd        (host_cmd_vd),
    .host_cmd           (host_cmd),
    .host_busy          (host_busy),
    .host_done          (host_done),
    .host_status        (host_status),
    .host_runctrl_we    (host_runctrl_we),
    .host_runctrl       (host_runctrl),
    .host_instr_we      (host_instr_we),
    .host_instr         (host_instr),
    .host_dreg_we       (host_dreg_we),
    .host_dreg_wdata    (host_dreg_wdata),
    .host_dreg_rdata    (host_dreg_rdata),
    .host_dreg_upd      (host_dreg_upd),
    .host_hart_state    (host_hart_state),
    .dbgc_hart_cmd      (dbgc_hart_cmd),
    .dbgc_hart_cmd_req  (dbgc_hart_cmd_req),
    .dbgc_hart_cmd_ack  (dbgc_hart_cmd_ack),
    .dbgc_hart_cmd_nack (dbgc_hart_cmd_nack),
    .dbgc_hart_runctrl  (dbgc_hart_runctrl),
    .dbgc_hart_state    (dbgc_hart_state),
    .dbgc_hart_instr    (dbgc_hart_instr),
    .dbgc_hart_dreg_out (dbgc_hart_dreg_out),
    .dbgc_hart_dreg_in  (dbgc_hart_dreg_in),
    .dbgc_hart_dreg_wr  (dbgc_hart_dreg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rc_we;
    logic [5:0]  rc;
    logic        in_we;
    logic [31:0] instr;
    logic        dw_we;
    logic [31:0] dw;
    logic        hw_wr;
    logic [31:0] hw;
    logic [7:0]  hs;
    logic [5:0]  e_rc;
    logic [31:0] e_instr;
    logic [31:0] e_dout;
    logic [31:0] e_rdata;
    logic        e_upd;
    logic [7:0]  e_hs;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Issues one command and drives the response on the resp_at-th REQ cycle (0 = never).
  task automatic do_cmd(input type_scr1_dbgc_hart_dbg_mode_e cmd, input int resp_at,
                        input logic a, input logic n, input int limit,
                        output int req_cnt, output logic got_done);
    host_cmd_vd = 1'b1;
    host_cmd    = cmd;
    tick();
    host_cmd_vd = 1'b0;
    req_cnt  = 0;
    got_done = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      if (dbgc_hart_cmd_req) req_cnt++;
      if (c == resp_at) begin
        dbgc_hart_cmd_ack  = a;
        dbgc_hart_cmd_nack = n;
      end
      tick();
      dbgc_hart_cmd_ack  = 1'b0;
      dbgc_hart_cmd_nack = 1'b0;
      if (host_done) begin
        got_done = 1'b1;
        break;
      end
    end
  endtask

  int   req_cnt;
  logic got_done;
  logic done_seen;

  initial begin
    vecs[0] = '{1, 6'h15, 1, 32'h0010_0073, 0, 32'h0, 0, 32'h0, 8'h81,
                6'h15, 32'h0010_0073, 32'h0, 32'h0, 0, 8'h81};
    vecs[1] = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 1, 32'hDEAD_BEEF, 8'h02,
                6'h15, 32'h0010_0073, 32'h0, 32'hDEAD_BEEF, 1, 8'h02};
    vecs[2] = '{0, 6'h00, 0, 32'h0, 0, 32'h0, 0, 32'h1111_1111, 8'h00,
                6'h15, 32'h0010_0073, 32'h0, 32'hDEAD_BEEF, 1, 8'h00};
    vecs[3] = '{0, 6'h00, 0, 32'h0, 1, 32'h0000_CAFE, 0, 32'h0, 8'h20,
                6'h15, 32'h0010_0073, 32'h0000_CAFE, 32'hDEAD_BEEF, 0, 8'h20};
    vecs[4] = '{0, 6'h00, 0, 32'h0, 1, 32'hA5A5_0001, 1, 32'h1234_5678, 8'h20,
                6'h15, 32'h0010_0073, 32'hA5A5_0001, 32'h1234_5678, 1, 8'h20};
    vecs[5] = '{0, 6'h3F, 0, 32'hFFFF_FFFF, 0, 32'h5555_5555, 0, 32'h0, 8'h00,
                6'h15, 32'h0010_0073, 32'hA5A5_0001, 32'h1234_5678, 1, 8'h00};
    vecs[6] = '{1, 6'h2A, 0, 32'h0, 0, 32'h0, 0, 32'h0, 8'h00,
                6'h2A, 32'h0010_0073, 32'hA5A5_0001, 32'h1234_5678, 1, 8'h00};

    rst_n              = 1'b0;
    host_cmd_vd        = 1'b0;
    host_cmd           = RUN_MODE;
    host_runctrl_we    = 1'b0;
    host_runctrl       = '0;
    host_instr_we      = 1'b0;
    host_instr         = '0;
    host_dreg_we       = 1'b0;
    host_dreg_wdata    = '0;
    dbgc_hart_cmd_ack  = 1'b0;
    dbgc_hart_cmd_nack = 1'b0;
    dbgc_hart_state    = '0;
    dbgc_hart_dreg_in  = '0;
    dbgc_hart_dreg_wr  = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    chk("rst busy",     32'(host_busy),          32'h0);
    chk("rst done",     32'(host_done),          32'h0);
    chk("rst status",   32'(host_status),        32'h0);
    chk("rst req",      32'(dbgc_hart_cmd_req),  32'h0);
    chk("rst cmd",      32'(dbgc_hart_cmd),      32'(RUN_MODE));
    chk("rst upd",      32'(host_dreg_upd),      32'h0);
    chk("rst runctrl",  32'(dbgc_hart_runctrl),  32'h0);
    chk("rst instr",    dbgc_hart_instr,         32'h0);
    chk("rst dreg_out", dbgc_hart_dreg_out,      32'h0);
    chk("rst rdata",    host_dreg_rdata,         32'h0);

    for (int i = 0; i < 7; i++) begin
      host_runctrl_we   = vecs[i].rc_we;
      host_runctrl      = type_scr1_dbgc_hart_runctrl_s'(vecs[i].rc);
      host_instr_we     = vecs[i].in_we;
      host_instr        = vecs[i].instr;
      host_dreg_we      = vecs[i].dw_we;
      host_dreg_wdata   = vecs[i].dw;
      dbgc_hart_dreg_wr = vecs[i].hw_wr;
      dbgc_hart_dreg_in = vecs[i].hw;
      dbgc_hart_state   = type_scr1_dbgc_hart_state_s'(vecs[i].hs);
      tick();
      host_runctrl_we   = 1'b0;
      host_instr_we     = 1'b0;
      host_dreg_we      = 1'b0;
      dbgc_hart_dreg_wr = 1'b0;
      chk($sformatf("vec%0d runctrl", i), 32'(dbgc_hart_runctrl), 32'(vecs[i].e_rc));
      chk($sformatf("vec%0d instr", i),   dbgc_hart_instr,        vecs[i].e_instr);
      chk($sformatf("vec%0d dreg_out", i), dbgc_hart_dreg_out,    vecs[i].e_dout);
      chk($sformatf("vec%0d rdata", i),   host_dreg_rdata,        vecs[i].e_rdata);
      chk($sformatf("vec%0d upd", i),     32'(host_dreg_upd),     32'(vecs[i].e_upd));
      chk($sformatf("vec%0d hart_state", i), 32'(host_hart_state), 32'(vecs[i].e_hs));
    end

    // run request while hart is running, nack on the first REQ cycle
    dbgc_hart_state = '0;
    do_cmd(RUN_MODE, 1, 1'b0, 1'b1, 20, req_cnt, got_done);
    chk("nack done",    32'(got_done),    32'h1);
    chk("nack req cyc", 32'(req_cnt),     32'd1);
    chk("nack status",  32'(host_status), 32'(SCR1_DBGC_HART_STS_NACK));
    chk("nack cmd",     32'(dbgc_hart_cmd), 32'(RUN_MODE));
    tick();
    chk("nack done pulse", 32'(host_done), 32'h0);
    chk("nack busy after", 32'(host_busy), 32'h0);

    // halt, ack on the third REQ cycle
    do_cmd(DBG_MODE, 3, 1'b1, 1'b0, 20, req_cnt, got_done);
    chk("ack done",    32'(got_done),    32'h1);
    chk("ack req cyc", 32'(req_cnt),     32'd3);
    chk("ack status",  32'(host_status), 32'(SCR1_DBGC_HART_STS_ACK));
    chk("ack req low", 32'(dbgc_hart_cmd_req), 32'h0);
    tick();
    chk("ack done pulse", 32'(host_done), 32'h0);
    chk("ack busy after", 32'(host_busy), 32'h0);

    // ack+nack together, with an ignored strobe and RUNCTRL write during REQ
    host_cmd_vd = 1'b1;
    host_cmd    = DBG_MODE;
    tick();
    host_cmd_vd = 1'b0;
    chk("t4 req",  32'(dbgc_hart_cmd_req), 32'h1);
    chk("t4 busy", 32'(host_busy),         32'h1);
    chk("t4 cmd",  32'(dbgc_hart_cmd),     32'(DBG_MODE));
    host_cmd_vd     = 1'b1;
    host_cmd        = RUN_MODE;
    host_runctrl_we = 1'b1;
    host_runctrl    = type_scr1_dbgc_hart_runctrl_s'(6'h01);
    tick();
    host_cmd_vd     = 1'b0;
    host_runctrl_we = 1'b0;
    chk("t4 cmd stable",     32'(dbgc_hart_cmd),     32'(DBG_MODE));
    chk("t4 runctrl frozen", 32'(dbgc_hart_runctrl), 32'h2A);
    chk("t4 req held",       32'(dbgc_hart_cmd_req), 32'h1);
    dbgc_hart_cmd_ack  = 1'b1;
    dbgc_hart_cmd_nack = 1'b1;
    tick();
    dbgc_hart_cmd_ack  = 1'b0;
    dbgc_hart_cmd_nack = 1'b0;
    chk("t4 done",   32'(host_done),   32'h1);
    chk("t4 status", 32'(host_status), 32'(SCR1_DBGC_HART_STS_NACK));
    tick();
    tick();
    chk("t4 no restart", 32'(dbgc_hart_cmd_req), 32'h0);

`ifdef SCR1_DBGC_HART_CMD_TOUT_EN
    do_cmd(DBG_MODE, 0, 1'b0, 1'b0, 400, req_cnt, got_done);
    chk("tout done",    32'(got_done),    32'h1);
    chk("tout req cyc", 32'(req_cnt),     32'd8);
    chk("tout status",  32'(host_status), 32'(SCR1_DBGC_HART_STS_TOUT));
    tick();
    chk("tout busy after", 32'(host_busy), 32'h0);
`else
    // no local timeout: req must hold for well over 100 cycles until the hart answers
    host_cmd_vd = 1'b1;
    host_cmd    = DBG_MODE;
    tick();
    host_cmd_vd = 1'b0;
    req_cnt   = 0;
    done_seen = 1'b0;
    for (int c = 0; c < 150; c++) begin
      if (dbgc_hart_cmd_req) req_cnt++;
      done_seen = done_seen | host_done;
      tick();
    end
    chk("notout req cyc", 32'(req_cnt),   32'd150);
    chk("notout no done", 32'(done_seen), 32'h0);
    dbgc_hart_cmd_nack = 1'b1;
    tick();
    dbgc_hart_cmd_nack = 1'b0;
    chk("notout done",   32'(host_done),   32'h1);
    chk("notout status", 32'(host_status), 32'(SCR1_DBGC_HART_STS_NACK));
    tick();
`endif

    // asynchronous reset in the middle of REQ
    tick();
    host_cmd_vd = 1'b1;
    host_cmd    = DBG_MODE;
    tick();
    host_cmd_vd = 1'b0;
    chk("t6 req before", 32'(dbgc_hart_cmd_req), 32'h1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6 req async",  32'(dbgc_hart_cmd_req), 32'h0);
    chk("t6 busy async", 32'(host_busy),         32'h0);
    chk("t6 status",     32'(host_status),       32'(SCR1_DBGC_HART_STS_ACK));
    done_seen = host_done;
    for (int c = 0; c < 3; c++) begin
      tick();
      done_seen = done_seen | host_done;
    end
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      done_seen = done_seen | host_done;
    end
    chk("t6 no done",   32'(done_seen),         32'h0);
    chk("t6 idle req",  32'(dbgc_hart_cmd_req), 32'h0);
    do_cmd(DBG_MODE, 1, 1'b1, 1'b0, 20, req_cnt, got_done);
    chk("t6 cmd after rst done", 32'(got_done), 32'h1);
    chk("t6 cmd after rst req",  32'(req_cnt),  32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
